// File: rtl/ring_pkg.sv
// Ring word field layout shared by the ring node and its helpers.
// Fields sit from the top of the word down: FULL, DEST, SRC; PAYLOAD is the low byte.
package ring_pkg;

  localparam int PAYLOAD_LO = 0;
  localparam int PAYLOAD_W  = 8;

  // An empty slot is all-zero; callers slice this to their word width.
  localparam logic [63:0] RING_EMPTY = '0;

  function automatic int full_pos(input int width);
    return width - 1;
  endfunction

  function automatic int dest_lo(input int width, input int abits);
    return width - 1 - abits;
  endfunction

  function automatic int src_lo(input int width, input int abits);
    return width - 1 - 2 * abits;
  endfunction

endpackage

// File: rtl/ring_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags; the head is valid while !empty.
// Latency: one edge from push to visible. Backpressure: push is ignored when full, pop is ignored when empty.
module ring_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [AW:0]       wptr_n, rptr_n;
  logic              do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
  assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};
  assign head    = mem[rptr[AW-1:0]];

  // The extra pointer bit separates the wrapped-full case from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      empty <= (wptr_n == rptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ring_fifo_node.sv
// Token-ring node with parallel client FIFOs; captures words for ADDRESS, removes orphans, injects into free slots.
// Latency: one register stage to toring. Backpressure: tx_ready drops when tx FIFO full; a full rx FIFO lets own words pass by.
module ring_fifo_node
  import ring_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ABITS   = 3,
  parameter int ADDRESS = 0,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fromring,
  output logic [WIDTH-1:0] toring,
  input  logic [7:0]       tx_data,
  input  logic [ABITS-1:0] tx_dest,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic [ABITS-1:0] rx_src,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       drop_count
);

  localparam int FULL_B  = full_pos(WIDTH);
  localparam int DEST_LO = dest_lo(WIDTH, ABITS);
  localparam int SRC_LO  = src_lo(WIDTH, ABITS);
  localparam int ENTRY_W = PAYLOAD_W + ABITS;
  localparam logic [ABITS-1:0] MY_ADDR = ABITS'(ADDRESS);

  logic             f_full;
  logic [ABITS-1:0] f_dest, f_src;
  logic             cap, orphan, slot_free, inject;
  logic             tx_full, tx_empty, rx_full, rx_empty, tx_push;
  logic [ENTRY_W-1:0] tx_head, rx_head;
  logic [WIDTH-1:0] next_word;
  logic             unused_mid;

  assign f_full     = fromring[FULL_B];
  assign f_dest     = fromring[DEST_LO +: ABITS];
  assign f_src      = fromring[SRC_LO +: ABITS];
  assign unused_mid = ^fromring[SRC_LO-1:PAYLOAD_W];

  assign cap       = f_full && (f_dest == MY_ADDR) && !rx_full;
  assign orphan    = f_full && (f_src == MY_ADDR) && (f_dest != MY_ADDR);
  assign slot_free = !f_full || cap || orphan;
  assign inject    = slot_free && !tx_empty;

  assign tx_ready = !rst && !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_head[PAYLOAD_W-1:0];
  assign rx_src   = rx_head[PAYLOAD_W +: ABITS];

  always_comb begin
    next_word = RING_EMPTY[WIDTH-1:0];
    if (inject) begin
      next_word[FULL_B]                     = 1'b1;
      next_word[DEST_LO +: ABITS]           = tx_head[PAYLOAD_W +: ABITS];
      next_word[SRC_LO +: ABITS]            = MY_ADDR;
      next_word[PAYLOAD_LO +: PAYLOAD_W]    = tx_head[PAYLOAD_W-1:0];
    end else if (!slot_free) begin
      next_word = fromring;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toring     <= '0;
      drop_count <= '0;
    end else begin
      toring <= next_word;
      if (orphan && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  ring_sync_fifo #(.DATA_W(ENTRY_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data ({tx_dest, tx_data}),
    .pop       (inject),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  ring_sync_fifo #(.DATA_W(ENTRY_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap),
    .push_data ({f_src, fromring[PAYLOAD_W-1:0]}),
    .pop       (rx_ready),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

endmodule

// File: tb/tb_ring_fifo_node.sv
// Directed and randomized checks of ring_fifo_node against a queue-based slot model (ADDRESS=2).
module tb_ring_fifo_node;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fromring;
  logic [15:0] toring;
  logic [7:0]  tx_data;
  logic [2:0]  tx_dest;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic [2:0]  rx_src;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_err = 0;

  // Model state: client queues hold {addr, payload}; plus the two output registers.
  logic [10:0] txq[$];
  logic [10:0] rxq[$];
  logic [15:0] tor_m;
  int          drop_m;

  ring_fifo_node #(.WIDTH(16), .ABITS(3), .ADDRESS(2), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fromring   (fromring),
    .toring     (toring),
    .tx_data    (tx_data),
    .tx_dest    (tx_dest),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_src     (rx_src),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called just after a negedge: drive, check the current outputs, then advance the model across the posedge.
  task automatic cycle(input logic [15:0] fr, input logic tv, input logic [2:0] td,
                       input logic [7:0] tdat, input logic rr, input logic r);
    logic [10:0] ntx[$];
    logic [10:0] nrx[$];
    logic [10:0] h;
    logic [15:0] nxt;
    logic        wfull, cap, orph, free;
    int          ndrop;
    fromring = fr; tx_valid = tv; tx_dest = td; tx_data = tdat; rx_ready = rr; rst = r;
    #1;
    chk("toring", toring, tor_m);
    chk("drop_count", drop_count, drop_m);
    chk("rx_valid", rx_valid, rxq.size() > 0);
    chk("tx_ready", tx_ready, !r && txq.size() < 4);
    if (rxq.size() > 0) begin
      chk("rx_data", rx_data, rxq[0][7:0]);
      chk("rx_src", rx_src, rxq[0][10:8]);
    end
    ntx = txq; nrx = rxq; ndrop = drop_m; nxt = 16'h0;
    if (r) begin
      ntx = {}; nrx = {}; ndrop = 0;
    end else begin
      wfull = fr[15];
      cap   = wfull && fr[14:12] == 3'd2 && rxq.size() < 4;
      orph  = wfull && fr[11:9] == 3'd2 && fr[14:12] != 3'd2;
      free  = !wfull || cap || orph;
      if (free && txq.size() > 0) begin
        h = ntx.pop_front();
        nxt = {1'b1, h[10:8], 3'd2, 1'b0, h[7:0]};
      end else if (!free) begin
        nxt = fr;
      end
      if (orph && ndrop < 255) ndrop++;
      if (tv && txq.size() < 4) ntx.push_back({td, tdat});
      if (rr && rxq.size() > 0) void'(nrx.pop_front());
      if (cap) nrx.push_back({fr[11:9], fr[7:0]});
    end
    @(posedge clk);
    txq = ntx; rxq = nrx; drop_m = ndrop; tor_m = nxt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fromring = '0; tx_valid = 1'b0; tx_dest = '0; tx_data = '0; rx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    txq = {}; rxq = {}; tor_m = '0; drop_m = 0;

    // Reset values
    cycle(16'h0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b1);
    chk("rst_toring", toring, 16'h0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_drop", drop_count, 8'h0);
    rst = 1'b0; #1;
    chk("post_rst_tx_ready", tx_ready, 1'b1);

    // Pass-through
    cycle(16'hC1AA, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("pass", toring, 16'hC1AA);

    // Capture
    cycle(16'hA15A, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("cap_toring", toring, 16'h0);
    chk("cap_rx_valid", rx_valid, 1'b1);
    chk("cap_rx_data", rx_data, 8'h5A);
    chk("cap_rx_src", rx_src, 3'd0);
    cycle(16'h0, 1'b0, 3'd0, 8'h0, 1'b1, 1'b0);

    // Inject exactly once
    cycle(16'h0, 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0);
    cycle(16'h0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("inject", toring, 16'hD43C);
    cycle(16'h0, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("inject_once", toring, 16'h0);

    // Back-pressure: the fifth word for node 2 passes through
    for (int i = 0; i < 5; i++) cycle(16'hA100 | 16'(i), 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("bp_pass", toring, 16'hA104);
    chk("bp_tx_ready", tx_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", rx_data, 8'(i));
      cycle(16'h0, 1'b0, 3'd0, 8'h0, 1'b1, 1'b0);
    end

    // Orphan removal and saturation
    cycle(16'hD4FF, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("orphan_toring", toring, 16'h0);
    chk("orphan_drop1", drop_count, 8'd1);
    for (int i = 0; i < 299; i++) cycle(16'hD4FF, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("orphan_sat", drop_count, 8'd255);

    // Capture and inject in the same cycle, then reset mid-stream
    cycle(16'h0, 1'b1, 3'd1, 8'h77, 1'b0, 1'b0);
    cycle(16'hA133, 1'b0, 3'd0, 8'h0, 1'b0, 1'b0);
    chk("capinj_toring", toring, 16'h9477);
    chk("capinj_rx_data", rx_data, 8'h33);
    cycle(16'h0, 1'b1, 3'd3, 8'h11, 1'b0, 1'b0);
    cycle(16'hC1AA, 1'b1, 3'd3, 8'h12, 1'b0, 1'b1);
    chk("midrst_toring", toring, 16'h0);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_drop", drop_count, 8'h0);

    // Randomized traffic against the model, biased toward node 2 and with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[14:12] = 3'd2;
      if ($urandom_range(0, 3) == 0) w[11:9] = 3'd2;
      cycle(w, 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ring_fifo_node.md
# ring_fifo_node

Buffered ring node with a parallel client port. It sits in the token ring between other nodes and is the parallel-interface counterpart of the SPI-attached node. Words on the ring addressed to this node are captured into a receive FIFO. Bytes the client queues into a transmit FIFO are injected into empty ring slots. All other words pass through after one register stage.

## Interface
Parameters:
- WIDTH, 16: ring word width; must satisfy WIDTH >= 2*ABITS+9
- ABITS, 3: node address width
- ADDRESS, 0: this node's ring address
- DEPTH, 4: entries per FIFO; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fromring  in  WIDTH  word from the upstream node
- toring  out  WIDTH  registered word to the downstream node
- tx_data  in  8  client payload to send
- tx_dest  in  ABITS  destination address
- tx_valid  in  1  client offers a word
- tx_ready  out  1  tx FIFO not full
- rx_data  out  8  head-of-rx-FIFO payload
- rx_src  out  ABITS  head-of-rx-FIFO source address
- rx_valid  out  1  rx FIFO not empty
- rx_ready  in  1  client consumes head
- drop_count  out  8  saturating count of orphaned words removed

## Operation
Ring word fields:
- FULL = bit WIDTH-1
- DEST = next ABITS bits below FULL
- SRC = next ABITS bits below DEST
- PAYLOAD = [7:0]
- Remaining middle bits are zero when generated and ignored when received.
- An empty slot has FULL=0.

Per-cycle slot decision, in priority order, on `fromring`:
1. FULL and DEST==ADDRESS: captured if the rx FIFO is not full (registered flag), and the slot becomes empty. If the rx FIFO is full, the word passes through unchanged.
2. FULL, SRC==ADDRESS and DEST!=ADDRESS: the word has circled the ring undelivered. Remove it (slot becomes empty) and increment `drop_count`, saturating at 255.
3. Otherwise, FULL words pass through unchanged.
4. If the slot is empty, or was emptied by rule 1 or 2 this cycle, and the tx FIFO is non-empty: pop the tx FIFO and inject {FULL=1, DEST=tx_dest, SRC=ADDRESS, PAYLOAD=tx_data}, with middle bits zero. Otherwise forward the empty slot as all-zero.

Client side:
- tx FIFO pushes when tx_valid && tx_ready.
- rx FIFO pops when rx_valid && rx_ready.
- Both FIFOs are show-ahead: the head is visible on rx_data/rx_src whenever rx_valid=1.

## Timing
- toring is registered: a decision made on cycle N's `fromring` appears on `toring` after edge N.
- Reset values (while rst=1 and after the reset edge): toring=0, both FIFOs empty, rx_valid=0, drop_count=0. tx_ready=0 while rst is high and 1 on the first cycle after.
- tx latency: a word accepted at edge E can appear on toring no earlier than after edge E+1, provided an empty slot arrives on cycle E+1.
- rx latency: a word captured at edge E gives rx_valid=1 in cycle E+1.
- Full and empty flags are registered state:
  - tx push while full is impossible because tx_ready=0.
  - The rx FIFO refuses a ring capture while full, even if the client pops that same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit, so full and empty are distinguished.
- Capture and inject in the same cycle (rule 1 followed by rule 4) are legal and both occur.
- Reset mid-operation discards FIFO contents and any slot in flight. toring is 0 on the next cycle.

## Structure
- Package `ring_pkg`:
  - field offset functions/constants for FULL, DEST, SRC and PAYLOAD, parameterised by WIDTH/ABITS
  - the empty-word constant
- Sub-module `ring_sync_fifo`:
  - parameters DATA_W and DEPTH
  - show-ahead, synchronous reset, registered full/empty
  - instantiated twice: tx with DATA_W=8+ABITS, rx with DATA_W=8+ABITS

## Test plan
All scenarios use ADDRESS=2, WIDTH=16, ABITS=3, DEPTH=4.
- Pass-through: fromring=0xC1AA (FULL, DEST=4, SRC=0) → toring=0xC1AA one cycle later; FIFOs unchanged.
- Capture: fromring=0xA1_5A (DEST=2, SRC=0, payload 0x5A) with tx FIFO empty → toring=0; next cycle rx_valid=1, rx_data=0x5A, rx_src=0.
- Inject: push tx_dest=5, tx_data=0x3C, then feed empty slots → toring=0xD43C (FULL, DEST=5, SRC=2) exactly once; tx FIFO then empty.
- Back-pressure: hold rx_ready=0 and send 5 words to node 2 → the first 4 are captured; the 5th passes through unchanged on toring; tx_ready is unaffected.
- Orphan removal: fromring=0xD4FF (SRC=2, DEST=5) → toring=0 and drop_count=1. Repeat 300 times → drop_count=255.
- Capture and inject in one cycle: tx FIFO holds (dest 1, 0x77) and an incoming word for node 2 arrives → toring=0x9477 and the rx FIFO gains the word. Assert rst mid-stream → toring=0, rx_valid=0, drop_count=0.
